// File: rtl/cifra_bcd_sched.sv
// Converts a selector row value to five glyph codes (sign + 4 digits) with serial
// double-dabble, then serves those codes per pixel for the numeric field of that row.
module cifra_bcd_sched #(
    parameter logic [10:0] X0      = 11'd16,
    parameter int          CW_LOG2 = 3,
    parameter int          ROW_H   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [12:0]        cifra,
    input  logic               znak,
    input  logic [10:0]        YO,
    input  logic [10:0]        X,
    input  logic [10:0]        Y,
    output logic [3:0]         glyph,
    output logic               glyph_en,
    output logic [CW_LOG2-1:0] glyph_col,
    output logic [4:0]         glyph_row,
    output logic               ready,
    output logic               busy
);

    localparam logic [10:0] FIELD_W   = 11'(5 << CW_LOG2);
    localparam logic [10:0] ROW_H_W   = 11'(ROW_H);
    localparam logic [3:0]  GLYPH_BLK = 4'd15;
    localparam logic [3:0]  GLYPH_MIN = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FMT} state_t;

    state_t      state, state_nxt;
    logic [10:0] yo_q;
    logic [10:0] yo_pend;
    logic [10:0] yo_disp;
    logic [12:0] sh;
    logic [15:0] bcd;
    logic        sgn;
    logic [3:0]  cnt;
    logic        disp_valid;
    logic [3:0]  disp_buf [5];
    logic [3:0]  fmt_buf  [5];
    logic        start;
    logic        do_shift;
    logic        do_write;
    logic [15:0] bcd_adj;
    logic [28:0] shifted;

    assign start = (YO != yo_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new row value always restarts the conversion, whatever state we are in.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (start)
                    state_nxt = S_SHIFT;
                else if (cnt == 4'd12)
                    state_nxt = S_FMT;
            end
            S_FMT:   state_nxt = start ? S_SHIFT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        do_shift = (state == S_SHIFT) && !start;
        do_write = (state == S_FMT) && !start;
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        shifted = {bcd_adj, sh} << 1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            yo_q    <= '0;
            yo_pend <= '0;
            sh      <= '0;
            bcd     <= '0;
            sgn     <= 1'b0;
            cnt     <= '0;
        end else begin
            yo_q <= YO;
            if (start) begin
                sh      <= cifra;
                bcd     <= '0;
                sgn     <= znak;
                yo_pend <= YO;
                cnt     <= '0;
            end else if (do_shift) begin
                bcd <= shifted[28:13];
                sh  <= shifted[12:0];
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Blank leading zeros from the thousands down; the units digit always shows.
    always_comb begin
        fmt_buf[0] = (sgn && (bcd != 16'd0)) ? GLYPH_MIN : GLYPH_BLK;
        fmt_buf[1] = (bcd[15:12] == 4'd0) ? GLYPH_BLK : bcd[15:12];
        fmt_buf[2] = (bcd[15:8] == 8'd0) ? GLYPH_BLK : bcd[11:8];
        fmt_buf[3] = (bcd[15:4] == 12'd0) ? GLYPH_BLK : bcd[7:4];
        fmt_buf[4] = bcd[3:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready      <= 1'b0;
            disp_valid <= 1'b0;
            yo_disp    <= '0;
            for (int i = 0; i < 5; i++)
                disp_buf[i] <= GLYPH_BLK;
        end else begin
            ready <= do_write;
            if (do_write) begin
                disp_valid <= 1'b1;
                yo_disp    <= yo_pend;
                for (int i = 0; i < 5; i++)
                    disp_buf[i] <= fmt_buf[i];
            end
        end
    end

    logic [10:0] dx, dy;
    logic        active;
    logic [2:0]  char_idx;
    logic [3:0]  cell_glyph;

    always_comb begin
        dx       = X - X0;
        dy       = Y - yo_disp;
        active   = disp_valid && (X >= X0) && (dx < FIELD_W) &&
                   (Y >= yo_disp) && (dy < ROW_H_W);
        char_idx = dx[CW_LOG2+2:CW_LOG2];
        case (char_idx)
            3'd0:    cell_glyph = disp_buf[0];
            3'd1:    cell_glyph = disp_buf[1];
            3'd2:    cell_glyph = disp_buf[2];
            3'd3:    cell_glyph = disp_buf[3];
            3'd4:    cell_glyph = disp_buf[4];
            default: cell_glyph = GLYPH_BLK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glyph     <= GLYPH_BLK;
            glyph_en  <= 1'b0;
            glyph_col <= '0;
            glyph_row <= '0;
        end else if (active) begin
            glyph     <= cell_glyph;
            glyph_en  <= 1'b1;
            glyph_col <= dx[CW_LOG2-1:0];
            glyph_row <= dy[4:0];
        end else begin
            glyph     <= GLYPH_BLK;
            glyph_en  <= 1'b0;
            glyph_col <= '0;
            glyph_row <= '0;
        end
    end

endmodule

// File: tb/tb_cifra_bcd_sched.sv
// Randomised and directed bench for cifra_bcd_sched against a decimal-arithmetic
// reference of the conversion timing, formatting and pixel lookup.
module tb_cifra_bcd_sched;

    localparam int X0 = 16;
    localparam int CW = 8;
    localparam int FW = 40;
    localparam int RH = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] cifra;
    logic        znak;
    logic [10:0] YO, X, Y;
    logic [3:0]  glyph;
    logic        glyph_en;
    logic [2:0]  glyph_col;
    logic [4:0]  glyph_row;
    logic        ready, busy;

    int errors = 0;
    int checks = 0;

    cifra_bcd_sched #(.X0(11'd16), .CW_LOG2(3), .ROW_H(16)) dut (
        .clk(clk), .reset_n(reset_n), .cifra(cifra), .znak(znak), .YO(YO),
        .X(X), .Y(Y), .glyph(glyph), .glyph_en(glyph_en), .glyph_col(glyph_col),
        .glyph_row(glyph_row), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: a conversion accepted at one edge lands in the buffer 14 edges later.
    int m_yo_q, m_cnt, m_val, m_yo, m_yo_disp;
    bit m_sgn, m_valid, m_ready;
    int m_buf [5];
    int m_glyph, m_en, m_col, m_row;

    function automatic void model_write(input int v, input bit s);
        int d [4];
        bit lead;
        d[0] = (v / 1000) % 10;
        d[1] = (v / 100) % 10;
        d[2] = (v / 10) % 10;
        d[3] = v % 10;
        lead = 1'b1;
        m_buf[0] = (s && v != 0) ? 10 : 15;
        for (int p = 0; p < 3; p++) begin
            if (lead && d[p] == 0) m_buf[p+1] = 15;
            else begin lead = 1'b0; m_buf[p+1] = d[p]; end
        end
        m_buf[4] = d[3];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_yo_q = 0; m_cnt = 0; m_valid = 0; m_yo_disp = 0; m_ready = 0;
            for (int i = 0; i < 5; i++) m_buf[i] = 15;
            m_glyph = 15; m_en = 0; m_col = 0; m_row = 0;
        end else begin
            if (m_valid && int'(X) >= X0 && int'(X) - X0 < FW &&
                int'(Y) >= m_yo_disp && int'(Y) - m_yo_disp < RH) begin
                m_glyph = m_buf[(int'(X) - X0) / CW];
                m_en    = 1;
                m_col   = (int'(X) - X0) % CW;
                m_row   = (int'(Y) - m_yo_disp) % 32;
            end else begin
                m_glyph = 15; m_en = 0; m_col = 0; m_row = 0;
            end
            m_ready = 0;
            if (int'(YO) != m_yo_q) begin
                m_yo_q = int'(YO); m_cnt = 14; m_val = int'(cifra); m_sgn = znak; m_yo = int'(YO);
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    model_write(m_val, m_sgn);
                    m_yo_disp = m_yo; m_valid = 1; m_ready = 1;
                end
            end
        end
    end

    // Drives a new row value at the current falling edge and counts edges until ready.
    task automatic run_conversion(input int val, input bit sgn, input int yo, output int lat);
        cifra = 13'(val); znak = sgn; YO = 11'(yo);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin lat = n; break; end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cifra = '0; znak = 1'b0; YO = '0; X = '0; Y = '0;
        repeat (3) @(negedge clk);
        checks++; if (glyph !== 4'd15) begin errors++; $display("[TB] FAIL reset glyph: got %0d expected 15", glyph); end
        checks++; if (glyph_en !== 1'b0) begin errors++; $display("[TB] FAIL reset glyph_en: got %0b expected 0", glyph_en); end
        checks++; if (glyph_col !== 3'd0) begin errors++; $display("[TB] FAIL reset glyph_col: got %0d expected 0", glyph_col); end
        checks++; if (glyph_row !== 5'd0) begin errors++; $display("[TB] FAIL reset glyph_row: got %0d expected 0", glyph_row); end
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset ready: got %0b expected 0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %0b expected 0", busy); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_value(input int val, input bit sgn, input int yo, input int row,
                              input logic [19:0] exp);
        int lat, e;
        run_conversion(val, sgn, yo, lat);
        checks++; if (lat != 15) begin errors++; $display("[TB] FAIL value %0d ready latency: got %0d expected 15", val, lat); end
        for (int x = X0; x < X0 + FW; x++) begin
            X = 11'(x); Y = 11'(yo + row);
            @(negedge clk);
            e = int'((exp >> (4 * (4 - (x - X0) / CW))) & 20'hF);
            checks++;
            if (glyph !== 4'(e) || glyph_en !== 1'b1 || glyph_col !== 3'((x - X0) % CW) || glyph_row !== 5'(row)) begin
                errors++;
                $display("[TB] FAIL value %0d sweep x=%0d: got glyph=%0d en=%0b col=%0d row=%0d expected glyph=%0d en=1 col=%0d row=%0d",
                         val, x, glyph, glyph_en, glyph_col, glyph_row, e, (x - X0) % CW, row);
            end
        end
    endtask

    task automatic test_restart;
        int lat, e;
        logic [19:0] exp;
        exp = {4'd15, 4'd15, 4'd15, 4'd4, 4'd2};
        cifra = 13'd1111; znak = 1'b0; YO = 11'h100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL restart early ready: got %0b expected 0", ready); end
        end
        run_conversion(42, 1'b0, 11'h120, lat);
        checks++; if (lat != 15) begin errors++; $display("[TB] FAIL restart latency: got %0d expected 15", lat); end
        for (int c = 0; c < 5; c++) begin
            X = 11'(X0 + c * CW + 3); Y = 11'h121;
            @(negedge clk);
            e = int'((exp >> (4 * (4 - c))) & 20'hF);
            checks++; if (glyph !== 4'(e) || glyph_en !== 1'b1) begin errors++; $display("[TB] FAIL restart char %0d: got %0d/%0b expected %0d/1", c, glyph, glyph_en, e); end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        cifra = 13'd7777; znak = 1'b1; YO = 11'h160;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b pre ready: got %0b expected 0", ready); end
        end
        run_conversion(42, 1'b1, 11'h180, lat);
        checks++; if (lat != 15) begin errors++; $display("[TB] FAIL b2b latency: got %0d expected 15", lat); end
        X = 11'(X0 + 1); Y = 11'h181;
        @(negedge clk);
        checks++; if (glyph !== 4'd10) begin errors++; $display("[TB] FAIL b2b sign: got %0d expected 10", glyph); end
        X = 11'(X0 + 4 * CW); Y = 11'h181;
        @(negedge clk);
        checks++; if (glyph !== 4'd2) begin errors++; $display("[TB] FAIL b2b units: got %0d expected 2", glyph); end
    endtask

    task automatic test_reset_mid;
        cifra = 13'd777; znak = 1'b0; YO = 11'h300;
        X = 11'(X0 + 4 * CW + 1); Y = 11'h182;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset busy before: got %0b expected 1", busy); end
        checks++; if (glyph_en !== 1'b1 || glyph !== 4'd2) begin errors++; $display("[TB] FAIL midreset old row: got %0d/%0b expected 2/1", glyph, glyph_en); end
        reset_n = 1'b0; YO = '0; cifra = '0;
        #1;
        checks++; if (glyph !== 4'd15 || glyph_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset glyph: got %0d/%0b expected 15/0", glyph, glyph_en); end
        checks++; if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset busy/ready: got %0b/%0b expected 0/0", busy, ready); end
        checks++; if (glyph_col !== 3'd0 || glyph_row !== 5'd0) begin errors++; $display("[TB] FAIL midreset col/row: got %0d/%0d expected 0/0", glyph_col, glyph_row); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            X = 11'(i + 4); Y = (i % 2 == 0) ? 11'(11'h180 + i % 16) : 11'(11'h300 + i % 16);
            @(negedge clk);
            checks++; if (glyph_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset frame i=%0d: got en=%0b busy=%0b expected 0/0", i, glyph_en, busy); end
        end
    endtask

    task automatic test_boundaries;
        int lat;
        int tbl [7][6] = '{
            '{15, 'h205, 0, 15, 0, 0}, '{56, 'h205, 0, 15, 0, 0},
            '{16, 'h205, 1, 15, 0, 5}, '{55, 'h205, 1, 4, 7, 5},
            '{30, 'h20F, 1, 1, 6, 15}, '{30, 'h210, 0, 15, 0, 0},
            '{30, 'h1FF, 0, 15, 0, 0}};
        run_conversion(1234, 1'b0, 11'h200, lat);
        checks++; if (lat != 15) begin errors++; $display("[TB] FAIL bound latency: got %0d expected 15", lat); end
        for (int i = 0; i < 7; i++) begin
            X = 11'(tbl[i][0]); Y = 11'(tbl[i][1]);
            @(negedge clk);
            checks++;
            if (glyph_en !== 1'(tbl[i][2]) || glyph !== 4'(tbl[i][3]) || glyph_col !== 3'(tbl[i][4]) || glyph_row !== 5'(tbl[i][5])) begin
                errors++;
                $display("[TB] FAIL bound x=%0d y=%0h: got en=%0b g=%0d col=%0d row=%0d expected en=%0d g=%0d col=%0d row=%0d",
                         tbl[i][0], tbl[i][1], glyph_en, glyph, glyph_col, glyph_row, tbl[i][2], tbl[i][3], tbl[i][4], tbl[i][5]);
            end
        end
    endtask

    task automatic test_random;
        int lat, yo, k, val;
        bit sgn;
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                do yo = $urandom_range(16, 1000); while (yo == int'(YO));
                cifra = 13'($urandom_range(0, 8191)); znak = 1'($urandom_range(0, 1)); YO = 11'(yo);
                k = $urandom_range(1, 14);
                for (int i = 0; i < k; i++) begin
                    @(negedge clk);
                    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL random abort ready it=%0d: got %0b expected 0", it, ready); end
                end
            end
            do yo = $urandom_range(16, 1000); while (yo == int'(YO));
            val = $urandom_range(0, 8191);
            sgn = 1'($urandom_range(0, 1));
            run_conversion(val, sgn, yo, lat);
            checks++; if (lat != 15) begin errors++; $display("[TB] FAIL random latency it=%0d: got %0d expected 15", it, lat); end
            for (int p = 0; p < 20; p++) begin
                X = 11'($urandom_range(0, 79));
                Y = 11'(yo - 4 + $urandom_range(0, 24));
                @(negedge clk);
                checks++;
                if (glyph !== 4'(m_glyph) || glyph_en !== 1'(m_en) || glyph_col !== 3'(m_col) || glyph_row !== 5'(m_row)) begin
                    errors++;
                    $display("[TB] FAIL random pixel val=%0d x=%0d y=%0d: got g=%0d en=%0b col=%0d row=%0d expected g=%0d en=%0d col=%0d row=%0d",
                             val, X, Y, glyph, glyph_en, glyph_col, glyph_row, m_glyph, m_en, m_col, m_row);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_value(1234, 1'b0, 11'h040, 5, {4'd15, 4'd1, 4'd2, 4'd3, 4'd4});
        test_value(0,    1'b1, 11'h050, 2, {4'd15, 4'd15, 4'd15, 4'd15, 4'd0});
        test_value(8191, 1'b1, 11'h060, 0, {4'd10, 4'd8, 4'd1, 4'd9, 4'd1});
        test_value(5,    1'b1, 11'h070, 15, {4'd10, 4'd15, 4'd15, 4'd15, 4'd5});
        test_restart;
        test_back_to_back;
        test_reset_mid;
        test_boundaries;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
